audio_framer: RTL



---
 rtl/ssr_audio_pkg.sv | 25 ++
 rtl/audio_frame_ram.sv | 35 +++
 rtl/audio_framer.sv | 137 +++++++++++++
 3 files changed

// File: rtl/ssr_audio_pkg.sv
// Shared constants and types for the audio front-end: framing geometry,
// framer state encoding and circular-buffer addressing.
package ssr_audio_pkg;

  localparam int SAMPLE_W  = 12;
  localparam int FEAT_W    = 16;
  localparam int FRAME_LEN = 256;
  localparam int HOP_LEN   = 128;
  localparam int DC_OFFSET = 2048;

  localparam int BUF_DEPTH = 2 * FRAME_LEN;
  localparam int BUF_AW    = $clog2(BUF_DEPTH);
  localparam int FRAME_W   = $clog2(FRAME_LEN);
  localparam int HOP_W     = (HOP_LEN > 1) ? $clog2(HOP_LEN) : 1;

  typedef enum logic [1:0] {
    ST_FILL   = 2'd0,
    ST_IDLE   = 2'd1,
    ST_LOAD   = 2'd2,
    ST_STREAM = 2'd3
  } framer_state_e;

  typedef logic [BUF_AW-1:0] buf_addr_t;

endpackage

// File: rtl/audio_frame_ram.sv
// Simple dual-port sample buffer: one write port, one registered read port.
// Storage is never reset; only the read register is, so the output reads 0.
module audio_frame_ram #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 9
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem_r [2**ADDR_W];

  // Write port
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[wr_addr] <= wr_data;
    end
  end

  // Registered read port; holds its value while rd_en is low
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data <= {DATA_W{1'b0}};
    end else if (rd_en) begin
      rd_data <= mem_r[rd_addr];
    end
  end

endmodule

// File: rtl/audio_framer.sv
// DC-removes and scales ADC samples into a circular buffer and streams
// overlapping frames over a valid/ready interface.
module audio_framer
  import ssr_audio_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic [SAMPLE_W-1:0] adc_data,
  input  logic                adc_valid,
  output logic [FEAT_W-1:0]   sample_out,
  output logic                sample_valid,
  input  logic                sample_ready,
  output logic                frame_start,
  output logic                frame_last,
  output logic                overflow,
  input  logic                overflow_clr
);

  localparam int OUT_W = FEAT_W;
  localparam int SHIFT = OUT_W - SAMPLE_W;

  framer_state_e      state_r, next_state_s;
  buf_addr_t          wr_ptr_r, base_r, pend_base_r, trig_base_s, rd_addr_s;
  logic [FRAME_W-1:0] fill_cnt_r, idx_r;
  logic [HOP_W-1:0]   hop_cnt_r;
  logic               pending_r, trigger_s, hs_s, last_hs_s, rd_en_s, busy_s, ovf_set_s;
  logic [SAMPLE_W:0]  centered_s;
  logic [OUT_W-1:0]   cond_s;

  // Low SAMPLE_W bits of the offset-removed code are its two's complement value
  assign centered_s = {1'b0, adc_data} - (SAMPLE_W+1)'(DC_OFFSET);
  assign cond_s     = {centered_s[SAMPLE_W-1:0], {SHIFT{1'b0}}};

  assign trigger_s   = adc_valid & ((state_r == ST_FILL) ? (fill_cnt_r == FRAME_W'(FRAME_LEN-1))
                                                         : (hop_cnt_r == HOP_W'(HOP_LEN-1)));
  assign trig_base_s = wr_ptr_r + BUF_AW'(1) - BUF_AW'(FRAME_LEN);
  assign hs_s        = sample_valid & sample_ready;
  assign last_hs_s   = hs_s & (idx_r == FRAME_W'(FRAME_LEN-1));
  assign busy_s      = (state_r == ST_LOAD) | (state_r == ST_STREAM);
  assign ovf_set_s   = busy_s & trigger_s & pending_r & ~last_hs_s;

  audio_frame_ram #(.DATA_W(OUT_W), .ADDR_W(BUF_AW)) u_ram (
    .clk     (clk),
    .rst     (rst),
    .we      (adc_valid),
    .wr_addr (wr_ptr_r),
    .wr_data (cond_s),
    .rd_en   (rd_en_s),
    .rd_addr (rd_addr_s),
    .rd_data (sample_out)
  );

  // Next-state and RAM read control; reads are prefetched on each handshake
  always_comb begin
    next_state_s = state_r;
    rd_en_s      = 1'b0;
    rd_addr_s    = base_r + BUF_AW'(idx_r) + BUF_AW'(1);
    case (state_r)
      ST_FILL, ST_IDLE: begin
        if (trigger_s) next_state_s = ST_LOAD;
        else           next_state_s = state_r;
      end
      ST_LOAD: begin
        rd_en_s      = 1'b1;
        rd_addr_s    = base_r;
        next_state_s = ST_STREAM;
      end
      ST_STREAM: begin
        if (last_hs_s)  next_state_s = (pending_r | trigger_s) ? ST_LOAD : ST_IDLE;
        else if (hs_s)  rd_en_s = 1'b1;
        else            next_state_s = ST_STREAM;
      end
      default: next_state_s = ST_FILL;
    endcase
  end

  // State, pointers, frame bookkeeping and registered stream flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= ST_FILL;
      wr_ptr_r     <= {BUF_AW{1'b0}};
      fill_cnt_r   <= {FRAME_W{1'b0}};
      hop_cnt_r    <= {HOP_W{1'b0}};
      idx_r        <= {FRAME_W{1'b0}};
      base_r       <= {BUF_AW{1'b0}};
      pend_base_r  <= {BUF_AW{1'b0}};
      pending_r    <= 1'b0;
      overflow     <= 1'b0;
      sample_valid <= 1'b0;
      frame_start  <= 1'b0;
      frame_last   <= 1'b0;
    end else begin
      state_r <= next_state_s;

      if (adc_valid) wr_ptr_r <= wr_ptr_r + BUF_AW'(1);
      if (adc_valid && state_r == ST_FILL) fill_cnt_r <= fill_cnt_r + FRAME_W'(1);
      if (adc_valid && state_r != ST_FILL)
        hop_cnt_r <= (hop_cnt_r == HOP_W'(HOP_LEN-1)) ? {HOP_W{1'b0}} : hop_cnt_r + HOP_W'(1);

      // A trigger racing the last handshake queues behind any pending frame
      if (!busy_s && trigger_s) begin
        base_r <= trig_base_s;
      end else if (last_hs_s) begin
        if (pending_r) begin
          base_r    <= pend_base_r;
          pending_r <= trigger_s;
          if (trigger_s) pend_base_r <= trig_base_s;
        end else if (trigger_s) begin
          base_r <= trig_base_s;
        end
      end else if (busy_s && trigger_s) begin
        pending_r   <= 1'b1;
        pend_base_r <= trig_base_s;
      end

      if (ovf_set_s)         overflow <= 1'b1;
      else if (overflow_clr) overflow <= 1'b0;

      if (state_r == ST_LOAD) begin
        sample_valid <= 1'b1;
        frame_start  <= 1'b1;
        frame_last   <= 1'b0;
        idx_r        <= {FRAME_W{1'b0}};
      end else if (last_hs_s) begin
        sample_valid <= 1'b0;
        frame_start  <= 1'b0;
        frame_last   <= 1'b0;
        idx_r        <= {FRAME_W{1'b0}};
      end else if (hs_s) begin
        idx_r       <= idx_r + FRAME_W'(1);
        frame_start <= 1'b0;
        frame_last  <= (idx_r == FRAME_W'(FRAME_LEN-2));
      end
    end
  end

endmodule
